// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button conditioning and CPU step-enable block.
package btn_pkg;

  localparam int unsigned DEFAULT_N_BTN    = 12;
  localparam int unsigned DEFAULT_STEP_BTN = 0;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  // Counter width for values 0..value-1, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while (width < 31 && (32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter and registered press/release pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CntW = clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d, db_prev_q;
  logic            press_q, release_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the debounced one.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      press_q   <= db_q & ~db_prev_q;
      release_q <= ~db_q & db_prev_q;
    end
  end

  assign btn_db      = db_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_step_ctrl.sv
// Button conditioning plus CPU clock-enable generation (single-step or free-run) and step count.
// Define BTN_AUTOREPEAT_EN to repeat steps while the step button is held in step mode.
module btn_step_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = DEFAULT_N_BTN,
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned STEP_BTN      = DEFAULT_STEP_BTN,
  parameter int unsigned RUN_DIV       = 1,
  parameter int unsigned REPEAT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic              step_mode,
  output logic [N_BTN-1:0]  btn_db,
  output logic [N_BTN-1:0]  btn_press,
  output logic [N_BTN-1:0]  btn_release,
  output logic              cpu_ce,
  output logic [15:0]       step_cnt
);

  localparam int unsigned DivW = clog2(RUN_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(RUN_DIV - 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_in[i]),
      .btn_db      (btn_db[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

  logic            mode_sync_q, mode_q, mode_prev_q;
  logic            mode_edge;
  logic [DivW-1:0] div_q, div_d;
  logic            cpu_ce_q, cpu_ce_d;
  logic [15:0]     step_cnt_q, step_cnt_d;
  logic            step_pulse;

  assign mode_edge = mode_q ^ mode_prev_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepW = clog2(REPEAT_CYCLES);
  localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_CYCLES - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_hold, rep_fire;

  // Counting restarts on the press pulse itself, so the first repeat lands a full period later.
  always_comb begin
    rep_hold  = (mode_q == MODE_STEP) & btn_db[STEP_BTN] & ~mode_edge & ~btn_press[STEP_BTN];
    rep_fire  = rep_hold & (rep_cnt_q == RepMax);
    rep_cnt_d = (rep_hold && !rep_fire) ? rep_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign step_pulse = btn_press[STEP_BTN] | rep_fire;
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
  assign step_pulse = btn_press[STEP_BTN];
`endif

  // A mode edge swallows the enable and any coincident press, and restarts the divider.
  always_comb begin
    div_d      = '0;
    cpu_ce_d   = 1'b0;
    step_cnt_d = step_cnt_q + 16'(cpu_ce_q);
    if (!mode_edge) begin
      case (mode_q)
        MODE_STEP: cpu_ce_d = step_pulse;
        MODE_RUN: begin
          cpu_ce_d = (div_q == DivMax);
          div_d    = (div_q == DivMax) ? '0 : div_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sync_q <= 1'b0;
      mode_q      <= 1'b0;
      mode_prev_q <= 1'b0;
      div_q       <= '0;
      cpu_ce_q    <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      mode_sync_q <= step_mode;
      mode_q      <= mode_sync_q;
      mode_prev_q <= mode_q;
      div_q       <= div_d;
      cpu_ce_q    <= cpu_ce_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl: a cycle model pushes expected outputs, a monitor compares.
module tb_btn_step_ctrl;

  localparam int unsigned N     = 12;
  localparam int unsigned DB    = 16;
  localparam int unsigned STEP  = 0;
  localparam int unsigned RDIV  = 1;
  localparam int unsigned REP   = 64;
  localparam int          LAT   = DB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn_in;
  logic          step_mode;
  logic [N-1:0]  btn_db, btn_press, btn_release;
  logic          cpu_ce;
  logic [15:0]   step_cnt;

  btn_step_ctrl #(
    .N_BTN         (N),
    .DB_CYCLES     (DB),
    .STEP_BTN      (STEP),
    .RUN_DIV       (RDIV),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .step_mode   (step_mode),
    .btn_db      (btn_db),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .cpu_ce      (cpu_ce),
    .step_cnt    (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] db;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic         ce;
    logic [15:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ce_seen = 0;
  int          press0_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model. The debounced level flips once the last DB synchronised samples (raw input
  // delayed two edges) all disagree with it; run-mode enables fall on every RDIV-th cycle since
  // the last clear; repeats fall on every REP-th cycle of an uninterrupted hold.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_db, m_db_prev, m_press, m_rel, n_db;
  logic         m_sync1, m_mode, m_mode_prev, m_ce, n_ce, m_edge, m_hold, m_fire, all_diff;
  logic [15:0]  m_cnt;
  int unsigned  run_age, rep_age;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hist = {};
      for (int k = 0; k <= DB; k++) hist.push_back('0);
      m_db = '0; m_db_prev = '0; m_press = '0; m_rel = '0;
      m_sync1 = 1'b0; m_mode = 1'b0; m_mode_prev = 1'b0; m_ce = 1'b0; m_cnt = '0;
      run_age = 0; rep_age = 0;
    end else begin
      n_db = m_db;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) n_db[i] = ~m_db[i];
      end
      m_edge = m_mode != m_mode_prev;
      m_hold = m_mode && m_db[STEP] && !m_edge && !m_press[STEP];
      m_fire = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      m_fire = m_hold && (rep_age % REP == REP - 1);
`endif
      if (m_edge) n_ce = 1'b0;
      else if (m_mode) n_ce = m_press[STEP] | m_fire;
      else n_ce = (run_age % RDIV) == RDIV - 1;
      run_age = (m_edge || m_mode) ? 0 : run_age + 1;
      rep_age = m_hold ? rep_age + 1 : 0;
      m_cnt = m_cnt + 16'(m_ce);
      m_ce = n_ce;
      m_press = m_db & ~m_db_prev;
      m_rel = ~m_db & m_db_prev;
      m_db_prev = m_db;
      m_db = n_db;
      m_mode_prev = m_mode;
      m_mode = m_sync1;
      m_sync1 = step_mode;
      hist.push_front(btn_in);
      void'(hist.pop_back());
    end
    exp_q.push_back('{db: m_db, press: m_press, rel: m_rel, ce: m_ce, cnt: m_cnt});
  end

  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      chk("scoreboard_depth", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("btn_db", 32'(btn_db), 32'(e.db));
      chk("btn_press", 32'(btn_press), 32'(e.press));
      chk("btn_release", 32'(btn_release), 32'(e.rel));
      chk("cpu_ce", 32'(cpu_ce), 32'(e.ce));
      chk("step_cnt", 32'(step_cnt), 32'(e.cnt));
    end
    if (cpu_ce === 1'b1) ce_seen++;
    if (btn_press[0] === 1'b1) press0_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Latency is counted from the first edge that samples the new level.
  task automatic wait_press0(input string name, input int base);
    int waited;
    int lat;
    waited = 0;
    while (btn_press[0] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    lat = (btn_press[0] === 1'b1) ? cyc - base - 1 : 'hFFFF;
    chk(name, 32'(lat), 32'(LAT));
  endtask

  int base, start, ce0, pr0;
  int glitch_len[3] = '{10, 15, 16};
  logic [N-1:0] flip;

  initial begin
    rst = 1'b1;
    btn_in = '0;
    step_mode = 1'b0;
    tick(3);
    chk("reset_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("reset_step_cnt", 32'(step_cnt), 32'd0);
    chk("reset_btn_db", 32'(btn_db), 32'd0);

    // Free run with RDIV = 1.
    rst = 1'b0;
    tick(1);
    chk("run_first_ce", 32'(cpu_ce), 32'd1);
    tick(10);
    chk("run_step_cnt_10", 32'(step_cnt), 32'd10);

    step_mode = 1'b1;
    tick(10);

    // Six clean presses.
    ce0 = ce_seen;
    for (int p = 0; p < 6; p++) begin
      btn_in[0] = 1'b1;
      base = cyc;
      start = cyc;
      wait_press0("press_latency", base);
      tick(50 - (cyc - start));
      btn_in[0] = 1'b0;
      tick(50);
    end
    chk("six_steps", 32'(ce_seen - ce0), 32'd6);

    // Glitches shorter than DB are ignored; a DB-cycle pulse qualifies.
    foreach (glitch_len[g]) begin
      ce0 = ce_seen;
      pr0 = press0_seen;
      btn_in[0] = 1'b1;
      tick(glitch_len[g]);
      btn_in[0] = 1'b0;
      tick(40);
      chk("glitch_press", 32'(press0_seen - pr0), (glitch_len[g] >= DB) ? 32'd1 : 32'd0);
      chk("glitch_ce", 32'(ce_seen - ce0), (glitch_len[g] >= DB) ? 32'd1 : 32'd0);
    end

    // Two buttons together: both pulse, one step.
    ce0 = ce_seen;
    btn_in[0] = 1'b1;
    btn_in[5] = 1'b1;
    base = cyc;
    wait_press0("dual_latency", base);
    chk("dual_press5", 32'(btn_press[5]), 32'd1);
    tick(30);
    btn_in = '0;
    tick(40);
    chk("dual_one_step", 32'(ce_seen - ce0), 32'd1);

    // Reset in the middle of debouncing a held button.
    btn_in[0] = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(3);
    chk("midrst_btn_db", 32'(btn_db), 32'd0);
    chk("midrst_step_cnt", 32'(step_cnt), 32'd0);
    chk("midrst_cpu_ce", 32'(cpu_ce), 32'd0);
    rst = 1'b0;
    base = cyc;
    wait_press0("midrst_latency", base);
    tick(10);
    btn_in[0] = 1'b0;
    tick(40);

    // Long hold: repeats only with auto-repeat compiled in.
    ce0 = ce_seen;
    btn_in[0] = 1'b1;
    tick(300);
    btn_in[0] = 1'b0;
    tick(40);
`ifdef BTN_AUTOREPEAT_EN
    chk("hold_steps", 32'(ce_seen - ce0), 32'd5);
`else
    chk("hold_steps", 32'(ce_seen - ce0), 32'd1);
`endif

    // Random mix of buttons, mode flips and resets, checked by the scoreboard.
    for (int it = 0; it < 120; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end else if (r < 14) begin
        step_mode = ~step_mode;
      end else begin
        flip = '0;
        flip[$urandom_range(0, N - 1)] = 1'b1;
        btn_in = btn_in ^ flip;
      end
      tick(int'($urandom_range(1, 40)));
    end
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
